led_blink_ctrl: RTL and testbench

//  Parametrised N-channel LED blink controller for the MAX II dev board top level.

---
 rtl/led_blink_pkg.sv | 21 ++
 rtl/led_blink_channel.sv | 86 ++++++++
 rtl/led_blink_ctrl.sv | 81 ++++++++
 tb/tb_led_blink_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared modes, channel state encoding and sizing helper
// for the LED blink controller.
package led_blink_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_SHOT  = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_BLINK = 2'd2,
    ST_SHOT  = 2'd3
  } ch_state_e;

  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: mode FSM, half-period counter,
// registered led/led_n and oneshot done pulse.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int         CNT_W        = 16,
  parameter int         DEFAULT_HALF = 500,
  parameter logic [1:0] RST_MODE     = MODE_BLINK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             we,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] half,
  output logic             led,
  output logic             led_n,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic RST_LED = (RST_MODE == MODE_ON);

  ch_state_e state, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] half_eff;
  logic led_d, done_d;

  assign half_eff = (half == '0) ? ONE : half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ch_state_e'(RST_MODE);
      half_q <= RST_HALF;
      cnt    <= RST_HALF - ONE;
      led    <= RST_LED;
      led_n  <= ~RST_LED;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      half_q <= half_d;
      cnt    <= cnt_d;
      led    <= led_d;
      led_n  <= ~led_d;
      done   <= done_d;
    end
  end

  // a write on this channel swallows a coincident tick
  always_comb begin
    state_d = state;
    half_d  = half_q;
    cnt_d   = cnt;
    led_d   = led;
    done_d  = 1'b0;
    unique case (1'b1)
      we: begin
        state_d = ch_state_e'(mode);
        half_d  = half_eff;
        cnt_d   = half_eff - ONE;
        led_d   = (mode != MODE_OFF);
      end
      (!we && tick && state == ST_BLINK): begin
        if (cnt == '0) begin
          led_d = ~led;
          cnt_d = half_q - ONE;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      (!we && tick && state == ST_SHOT): begin
        if (cnt == '0) begin
          led_d   = 1'b0;
          state_d = ST_OFF;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// N-channel LED blink controller: shared tick prescaler,
// config channel decode and one led_blink_channel per LED.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int         F_CLK        = 50000000,
  parameter int         TICK_HZ      = 1000,
  parameter int         N_CH         = 2,
  parameter int         CNT_W        = 16,
  parameter int         DEFAULT_HALF = 500,
  parameter logic [1:0] RST_MODE     = 2'd2
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        cfg_we_i,
  input  logic [ch_idx_w(N_CH)-1:0]   cfg_ch_i,
  input  logic [1:0]                  cfg_mode_i,
  input  logic [CNT_W-1:0]            cfg_half_i,
  output logic                        tick_o,
  output logic [N_CH-1:0]             led_o,
  output logic [N_CH-1:0]             led_n_o,
  output logic [N_CH-1:0]             done_o
);

  localparam int DIV  = F_CLK / TICK_HZ;
  localparam int PC_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("led_blink_ctrl: F_CLK/TICK_HZ must be >= 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_nch_chk
    $error("led_blink_ctrl: N_CH must be 1..16");
  end
  if (DEFAULT_HALF < 1 || DEFAULT_HALF > (2 ** CNT_W) - 1) begin : g_half_chk
    $error("led_blink_ctrl: DEFAULT_HALF out of range");
  end

  logic [PC_W-1:0] pc;
  logic            tick;
  logic [N_CH-1:0] ch_we;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc   <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pc == PC_LAST);
      pc   <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
    end
  end

  assign tick_o = tick;

  // out-of-range channel numbers match no channel
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_we[i] = cfg_we_i && (int'(cfg_ch_i) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_blink_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF),
      .RST_MODE     (RST_MODE)
    ) u_ch (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .tick  (tick),
      .we    (ch_we[g]),
      .mode  (cfg_mode_i),
      .half  (cfg_half_i),
      .led   (led_o[g]),
      .led_n (led_n_o[g]),
      .done  (done_o[g])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: directed writes,
// hand-computed checkpoints popped by a negedge monitor.
module tb_led_blink_ctrl;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_SHOT  = 2'd3;

  localparam int B  = 3;
  localparam int B2 = B + 553;

  logic        clk;
  logic        rst_n_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_ch_i;
  logic [1:0]  cfg_mode_i;
  logic [15:0] cfg_half_i;
  logic        tick_o;
  logic [2:0]  led_o;
  logic [2:0]  led_n_o;
  logic [2:0]  done_o;

  led_blink_ctrl #(
    .F_CLK        (1000),
    .TICK_HZ      (100),
    .N_CH         (3),
    .CNT_W        (16),
    .DEFAULT_HALF (3),
    .RST_MODE     (2'd2)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_mode_i (cfg_mode_i),
    .cfg_half_i (cfg_half_i),
    .tick_o     (tick_o),
    .led_o      (led_o),
    .led_n_o    (led_n_o),
    .done_o     (done_o)
  );

  typedef struct {
    int         cyc;
    logic [2:0] led;
    logic [2:0] done;
    logic       tick;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // expected tick: once every 10 cycles counted from reset release
  task automatic push(input int b, input int j, input logic [2:0] l,
                      input logic [2:0] d, input string nm);
    exp_t e;
    e.cyc  = b + j;
    e.led  = l;
    e.done = d;
    e.tick = (j >= 10) && (j % 10 == 0);
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic at(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic wr(input int e, input logic [1:0] ch,
                    input logic [1:0] m, input logic [15:0] h);
    at(e);
    cfg_we_i   = 1'b1;
    cfg_ch_i   = ch;
    cfg_mode_i = m;
    cfg_half_i = h;
    at(e + 1);
    cfg_we_i   = 1'b0;
  endtask

  exp_t cur;
  always @(negedge clk) begin
    checks++;
    if (led_n_o !== ~led_o) begin
      errors++;
      $display("FAIL led_n cyc=%0d led_n=%b led=%b", cyc, led_n_o, led_o);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed at cyc=%0d", cur.nm, cur.cyc);
      end else begin
        checks += 3;
        if (led_o !== cur.led) begin
          errors++;
          $display("FAIL %s led cyc=%0d got=%b exp=%b",
                   cur.nm, cyc, led_o, cur.led);
        end
        if (done_o !== cur.done) begin
          errors++;
          $display("FAIL %s done cyc=%0d got=%b exp=%b",
                   cur.nm, cyc, done_o, cur.done);
        end
        if (tick_o !== cur.tick) begin
          errors++;
          $display("FAIL %s tick cyc=%0d got=%b exp=%b",
                   cur.nm, cyc, tick_o, cur.tick);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i    = 1'b0;
    cfg_we_i   = 1'b0;
    cfg_ch_i   = 2'd0;
    cfg_mode_i = 2'd0;
    cfg_half_i = 16'd0;

    push(B, -1, 3'b000, 3'b000, "reset");
    push(B,  9, 3'b000, 3'b000, "pre_tick");
    push(B, 10, 3'b000, 3'b000, "first_tick");
    push(B, 11, 3'b000, 3'b000, "tick_1cyc");
    push(B, 20, 3'b000, 3'b000, "tick2");
    push(B, 30, 3'b000, 3'b000, "before_t3");
    push(B, 31, 3'b111, 3'b000, "toggle_on");
    push(B, 60, 3'b111, 3'b000, "hold_on");
    push(B, 61, 3'b000, 3'b000, "toggle_off");
    push(B, 91, 3'b111, 3'b000, "toggle_on2");
    at(B + 1);
    rst_n_i = 1'b1;

    push(B, 124, 3'b000, 3'b000, "pre_on");
    push(B, 125, 3'b010, 3'b000, "ch1_on");
    push(B, 154, 3'b111, 3'b000, "pre_off");
    push(B, 155, 3'b110, 3'b000, "ch0_off");
    push(B, 181, 3'b010, 3'b000, "stable1");
    push(B, 211, 3'b110, 3'b000, "stable2");
    push(B, 330, 3'b010, 3'b000, "stable3");
    wr(B + 125, 2'd1, M_ON, 16'd3);
    wr(B + 155, 2'd0, M_OFF, 16'd3);

    push(B, 365, 3'b011, 3'b000, "shot_start");
    push(B, 410, 3'b111, 3'b000, "shot_last");
    push(B, 411, 3'b110, 3'b001, "shot_done");
    push(B, 412, 3'b110, 3'b000, "done_1cyc");
    push(B, 450, 3'b010, 3'b000, "shot_stays");
    wr(B + 365, 2'd0, M_SHOT, 16'd5);

    push(B, 455, 3'b111, 3'b000, "half0_wr");
    push(B, 460, 3'b111, 3'b000, "half0_hold");
    push(B, 461, 3'b110, 3'b000, "half0_t1");
    push(B, 471, 3'b111, 3'b000, "half0_t2");
    push(B, 481, 3'b010, 3'b000, "half0_t3");
    wr(B + 455, 2'd0, M_BLINK, 16'd0);

    push(B, 490, 3'b010, 3'b000, "pre_coinc");
    push(B, 491, 3'b011, 3'b000, "coinc_wr");
    push(B, 501, 3'b010, 3'b000, "coinc_t1");
    push(B, 511, 3'b101, 3'b000, "coinc_t2");
    push(B, 531, 3'b111, 3'b000, "coinc_t4");
    wr(B + 491, 2'd1, M_BLINK, 16'd2);

    push(B, 535, 3'b111, 3'b000, "bad_ch");
    push(B, 540, 3'b111, 3'b000, "bad_ch_hold");
    push(B, 541, 3'b010, 3'b000, "bad_ch_run");
    wr(B + 535, 2'd3, M_OFF, 16'd1);

    push(B, 545, 3'b011, 3'b000, "shot2_start");
    push(B, 549, 3'b011, 3'b000, "pre_rst");
    push(B2, -3, 3'b000, 3'b000, "async_rst");
    push(B2, -1, 3'b000, 3'b000, "rst_hold");
    push(B2, 5, 3'b000, 3'b000, "rel_idle");
    push(B2, 10, 3'b000, 3'b000, "rel_tick");
    push(B2, 31, 3'b111, 3'b000, "rel_on");
    push(B2, 61, 3'b000, 3'b000, "rel_off");
    push(B2, 62, 3'b000, 3'b000, "rel_end");
    wr(B + 545, 2'd0, M_SHOT, 16'd5);
    at(B + 550);
    @(posedge clk);
    #1 rst_n_i = 1'b0;
    at(B2 + 1);
    rst_n_i = 1'b1;

    at(B2 + 75);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
